latch_framer: RTL and testbench
===============================

LATCH_FRAMER -- requirements
Module: latch_framer

Interface
REQ-001 Parameter pSYNC, default 2, number of synchroniser flops on each ready input (legal 2..4).
REQ-002 Parameter pHDR, default 3'b101, constant placed in header bits [7:5].
REQ-003 iCLK  input  1  single clock; all logic on its rising edge.
REQ-004 iRST_N  input  1  reset, synchronous, active-low.
REQ-005 iRdyCOUNTER1  input  1  level; channel-1 latched value valid; asynchronous to iCLK.
REQ-006 i1COUNTER / i1COUNTERHi  input  32 / 32  channel-1 latched value, low and high words; stable while iRdyCOUNTER1 is high.
REQ-007 iRdyCOUNTER2, i2COUNTER, i2COUNTERHi  input  1, 32, 32  channel-2 equivalents.
REQ-008 oResetLatch1 / oResetLatch2  output  1 / 1  one-cycle pulse releasing the upstream latch for that channel.
REQ-009 oTxData  output  8  outgoing byte.
REQ-010 oTxValid  output  1  oTxData valid.
REQ-011 iTxReady  input  1  sink accepts the byte; a transfer occurs on any edge where oTxValid and iTxReady are both high.
REQ-012 oBusy  output  1  high whenever the FSM is not IDLE.

Function
REQ-013 Each ready input SHALL pass through a pSYNC-flop synchroniser; only the synchronised level (rdyS1, rdyS2) is used.
REQ-014 Channel n SHALL be eligible when rdySn is 1 and pendClr[n] is 0.
REQ-015 FSM states: IDLE, SEND, ACK.
REQ-016 IDLE: if any channel is eligible, grant it, capture {iNCOUNTERHi, iNCOUNTER} into a 64-bit shadow register, build the header, clear the byte index, and go to SEND on the same edge.
REQ-017 Arbitration: if both channels are eligible, grant the channel not served last (round-robin); after reset, channel 1 wins the first tie.
REQ-018 Header = {pHDR, ch, seq[3:0]}, where ch = 0 for channel 1 and 1 for channel 2.
REQ-019 SEND: emit 9 bytes in this order: header, then shadow[7:0], [15:8], ... [63:56] (little-endian).
REQ-020 SEND: oTxValid = 1 and oTxData is held stable until the transfer; the byte index advances only on a transfer.
REQ-021 oTxValid SHALL never drop while a byte is untransferred.
REQ-022 SEND: after the 9th transfer, go to ACK and increment seq (4-bit, wraps 15 -> 0).
REQ-023 ACK: drive oResetLatchN = 1 for the granted channel for exactly one cycle, set pendClr[n], record the channel as last served, and go to IDLE.
REQ-024 ACK: oTxValid = 0.
REQ-025 pendClr[n] SHALL clear on the first edge at which rdySn is sampled 0, so that a latch held by a still-active upstream latch signal is never framed twice.
REQ-026 Latency: with the FSM IDLE and no competing channel, oTxValid rises exactly pSYNC+1 edges after the first edge that samples iRdyCOUNTERn high.
REQ-027 Minimum frame length with iTxReady held high is 9 SEND cycles plus 1 ACK cycle; back-to-back frames on alternating channels have a 1-cycle IDLE gap.
REQ-028 Channel inputs changing while their channel is in SEND SHALL NOT affect the frame in progress, because the shadow register was captured at grant.
REQ-029 A ready input falling during SEND SHALL NOT abort the frame; the ACK pulse is still issued.
REQ-030 oResetLatch1 and oResetLatch2 SHALL never be high in the same cycle.

Reset
REQ-031 With iRST_N = 0 at an edge, the block SHALL enter IDLE and clear the synchroniser flops, pendClr, seq, byte index and the last-served pointer (last-served reset value means channel 1 wins the next tie).
REQ-032 Output reset values: oTxValid = 0, oTxData = 8'h00, oResetLatch1 = 0, oResetLatch2 = 0, oBusy = 0.
REQ-033 Reset during SEND SHALL abandon the frame with no reset pulse; the upstream latch stays held, so the full frame is re-sent from the header once reset is released.

Verification
REQ-034 Channel-1 value 64'h0123_4567_89AB_CDEF, iTxReady = 1 -> bytes A0,EF,CD,AB,89,67,45,23,01, then one oResetLatch1 pulse; valid rises pSYNC+1 edges after ready.
REQ-035 Both ready inputs rise together -> channel-1 frame with header A0, then channel-2 frame with header B1; one pulse each, in that order.
REQ-036 iTxReady toggling 1-of-3 cycles -> oTxData and oTxValid stable across stalls; byte sequence identical to the unstalled case.
REQ-037 iRdyCOUNTER1 held high for 50 cycles after the ACK pulse -> no second frame; after it falls and rises again -> a new frame with seq+1.
REQ-038 17 consecutive channel-1 frames -> header seq values 0..15, then 0.
REQ-039 iRST_N low for 1 cycle after byte 4 of a frame -> oTxValid = 0 the next cycle, no pulse; the frame restarts with header seq = 0.

Source files
------------

// File: rtl/latch_framer.sv
// latch_framer: round-robin arbiter over two latched 64-bit counter channels,
// serialising each grant as a header + 8 little-endian payload bytes.
module latch_framer #(
   parameter int unsigned pSYNC = 2,
   parameter logic [2:0]  pHDR  = 3'b101
) (
   input  logic        iCLK,
   input  logic        iRST_N,
   input  logic        iRdyCOUNTER1,
   input  logic [31:0] i1COUNTER,
   input  logic [31:0] i1COUNTERHi,
   input  logic        iRdyCOUNTER2,
   input  logic [31:0] i2COUNTER,
   input  logic [31:0] i2COUNTERHi,
   output logic        oResetLatch1,
   output logic        oResetLatch2,
   output logic [7:0]  oTxData,
   output logic        oTxValid,
   input  logic        iTxReady,
   output logic        oBusy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      ACK  = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [pSYNC-1:0] sync1, sync2;
   logic             rdy_s1, rdy_s2;
   logic [1:0]       pend_clr;
   logic [3:0]       seq;
   logic [3:0]       idx;
   logic [63:0]      shadow;
   logic [7:0]       hdr;
   logic             ch;
   logic             rr_ch2;

   logic             elig1, elig2;
   logic             pick2, grant, xfer, ack, last_byte;
   logic [2:0]       bsel;
   logic [7:0]       frame_byte;

   assign rdy_s1 = sync1[pSYNC-1];
   assign rdy_s2 = sync2[pSYNC-1];

   always_comb begin
      elig1      = rdy_s1 & ~pend_clr[0];
      elig2      = rdy_s2 & ~pend_clr[1];
      pick2      = elig2 & (~elig1 | rr_ch2);
      grant      = 1'b0;
      xfer       = 1'b0;
      ack        = 1'b0;
      last_byte  = (idx == 4'd8);
      bsel       = idx[2:0] - 3'd1;
      frame_byte = (idx == 4'd0) ? hdr : shadow[{bsel, 3'b000} +: 8];
      state_nxt    = state;
      oTxValid     = 1'b0;
      oTxData      = 8'h00;
      oResetLatch1 = 1'b0;
      oResetLatch2 = 1'b0;
      oBusy        = (state != IDLE);
      unique case (state)
         IDLE: begin
            if (elig1 | elig2) begin
               grant     = 1'b1;
               state_nxt = SEND;
            end
         end
         SEND: begin
            oTxValid = 1'b1;
            oTxData  = frame_byte;
            xfer     = iTxReady;
            if (xfer && last_byte) state_nxt = ACK;
         end
         ACK: begin
            ack          = 1'b1;
            oResetLatch1 = ~ch;
            oResetLatch2 = ch;
            state_nxt    = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         state    <= IDLE;
         sync1    <= '0;
         sync2    <= '0;
         pend_clr <= '0;
         seq      <= '0;
         idx      <= '0;
         shadow   <= '0;
         hdr      <= '0;
         ch       <= 1'b0;
         rr_ch2   <= 1'b0;
      end else begin
         state <= state_nxt;
         sync1 <= {sync1[pSYNC-2:0], iRdyCOUNTER1};
         sync2 <= {sync2[pSYNC-2:0], iRdyCOUNTER2};
         // a served channel stays blocked until its ready is seen low
         pend_clr[0] <= rdy_s1 & (pend_clr[0] | (ack & ~ch));
         pend_clr[1] <= rdy_s2 & (pend_clr[1] | (ack & ch));
         if (grant) begin
            ch     <= pick2;
            shadow <= pick2 ? {i2COUNTERHi, i2COUNTER}
                            : {i1COUNTERHi, i1COUNTER};
            hdr    <= {pHDR, pick2, seq};
            idx    <= '0;
         end
         if (xfer) begin
            if (last_byte) seq <= seq + 4'd1;
            else           idx <= idx + 4'd1;
         end
         if (ack) rr_ch2 <= ~ch;
      end
   end

endmodule

// File: tb/tb_latch_framer.sv
// Randomised bench for latch_framer: a frame-level model predicts the byte
// stream and pulse order; a negedge monitor captures transfers and pulses.
module tb_latch_framer;

   localparam int PS = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rdy1, rdy2;
   logic [31:0] c1, c1hi, c2, c2hi;
   logic        rl1, rl2;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int mode   = 0;
   int m_seq  = 0;
   int p1 = 0, p2 = 0;

   logic [7:0] obs[$];
   logic [7:0] expf[$];
   int         pulses[$];

   logic       pv = 0, pr = 0, prst = 0;
   logic [7:0] pdat = 0;

   always #5 clk = ~clk;

   latch_framer #(.pSYNC(PS), .pHDR(3'b101)) dut (
      .iCLK(clk),
      .iRST_N(rst_n),
      .iRdyCOUNTER1(rdy1),
      .i1COUNTER(c1),
      .i1COUNTERHi(c1hi),
      .iRdyCOUNTER2(rdy2),
      .i2COUNTER(c2),
      .i2COUNTERHi(c2hi),
      .oResetLatch1(rl1),
      .oResetLatch2(rl2),
      .oTxData(tx_data),
      .oTxValid(tx_valid),
      .iTxReady(tx_ready),
      .oBusy(busy)
   );

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // sink readiness: 0 always, 1 one cycle in three, 2 random
   initial begin
      int phase = 0;
      tx_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (mode)
            1: begin
               tx_ready = (phase == 2);
               phase = (phase + 1) % 3;
            end
            2: tx_ready = 1'($urandom_range(0, 1));
            default: tx_ready = 1'b1;
         endcase
      end
   end

   always @(negedge clk) begin
      if (prst && rst_n && pv && !pr) begin
         check("hold_valid", 64'(tx_valid), 64'd1);
         check("hold_data", 64'(tx_data), 64'(pdat));
      end
      if (rl1 || rl2) begin
         check("pulse_excl", 64'(rl1 & rl2), 64'd0);
         if (rl1) begin p1++; pulses.push_back(1); end
         if (rl2) begin p2++; pulses.push_back(2); end
      end
      if (tx_valid && tx_ready && rst_n) obs.push_back(tx_data);
      pv   = tx_valid;
      pr   = tx_ready;
      pdat = tx_data;
      prst = rst_n;
   end

   task automatic model_frame(input bit ch2, input logic [63:0] v);
      expf.push_back({3'b101, ch2, 4'(m_seq)});
      for (int k = 0; k < 8; k++) expf.push_back(8'(v >> (8 * k)));
      m_seq = (m_seq + 1) % 16;
   endtask

   task automatic cmp_frames(input string tag);
      int n = 0;
      while (obs.size() < expf.size() && n < 2000) begin
         tick();
         n++;
      end
      check({tag, "_len"}, 64'(obs.size()), 64'(expf.size()));
      for (int i = 0; i < expf.size() && i < obs.size(); i++)
         check(tag, 64'(obs[i]), 64'(expf[i]));
      obs.delete();
      expf.delete();
   endtask

   task automatic wait_pulse(input int which, input int target,
                             input bit scramble);
      int n = 0;
      while (((which == 1) ? p1 : p2) < target && n < 1000) begin
         tick();
         n++;
         if (scramble && busy) begin
            if (which == 1) begin c1 = $urandom(); c1hi = $urandom(); end
            else            begin c2 = $urandom(); c2hi = $urandom(); end
         end
      end
      check("pulse_seen", 64'((which == 1) ? p1 : p2), 64'(target));
   endtask

   task automatic run_frame(input bit ch2, input logic [63:0] v);
      int t;
      if (ch2) begin {c2hi, c2} = v; rdy2 = 1'b1; t = p2 + 1; end
      else     begin {c1hi, c1} = v; rdy1 = 1'b1; t = p1 + 1; end
      wait_pulse(ch2 ? 2 : 1, t, 1'b1);
      rdy1 = 1'b0;
      rdy2 = 1'b0;
      tick(PS + 3);
      model_frame(ch2, v);
      cmp_frames("frame");
   endtask

   task automatic do_reset();
      rdy1  = 1'b0;
      rdy2  = 1'b0;
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      obs.delete();
      pulses.delete();
      m_seq = 0;
   endtask

   initial begin
      logic [63:0] v1, v2;
      int n, pc;
      rst_n = 1'b0;
      rdy1 = 1'b0; rdy2 = 1'b0;
      c1 = '0; c1hi = '0; c2 = '0; c2hi = '0;

      tick(3);
      check("rst_valid", 64'(tx_valid), 64'd0);
      check("rst_data", 64'(tx_data), 64'h00);
      check("rst_rl1", 64'(rl1), 64'd0);
      check("rst_rl2", 64'(rl2), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      do_reset();
      tick(2);

      // reference frame, ready always high, with latency measurement
      mode = 0;
      v1 = 64'h0123_4567_89AB_CDEF;
      {c1hi, c1} = v1;
      rdy1 = 1'b1;
      n = 0;
      while (!tx_valid && n < 20) begin
         tick();
         n++;
      end
      check("latency", 64'(n), 64'(PS + 1));
      wait_pulse(1, 1, 1'b0);
      check("no_rl2", 64'(p2), 64'd0);
      rdy1 = 1'b0;
      tick(PS + 3);
      model_frame(1'b0, v1);
      cmp_frames("ref_frame");

      // same value with 1-of-3 sink stalls
      mode = 1;
      run_frame(1'b0, v1);

      // ready held high long after the ack must not reframe
      mode = 2;
      v1 = {$urandom(), $urandom()};
      {c1hi, c1} = v1;
      rdy1 = 1'b1;
      pc = p1 + 1;
      wait_pulse(1, pc, 1'b1);
      model_frame(1'b0, v1);
      cmp_frames("held_frame");
      tick(50);
      check("no_reframe_bytes", 64'(obs.size()), 64'd0);
      check("no_reframe_pulse", 64'(p1), 64'(pc));
      rdy1 = 1'b0;
      tick(PS + 3);
      run_frame(1'b0, {$urandom(), $urandom()});

      // simultaneous requests after reset: channel 1 wins, then channel 2
      do_reset();
      tick(2);
      v1 = {$urandom(), $urandom()};
      v2 = {$urandom(), $urandom()};
      {c1hi, c1} = v1;
      {c2hi, c2} = v2;
      rdy1 = 1'b1;
      rdy2 = 1'b1;
      wait_pulse(2, p2 + 1, 1'b0);
      rdy1 = 1'b0;
      rdy2 = 1'b0;
      check("tie_npulses", 64'(pulses.size()), 64'd2);
      if (pulses.size() == 2) begin
         check("tie_first", 64'(pulses[0]), 64'd1);
         check("tie_second", 64'(pulses[1]), 64'd2);
      end
      tick(PS + 3);
      model_frame(1'b0, v1);
      model_frame(1'b1, v2);
      cmp_frames("tie_frames");

      // 17 frames: sequence wraps 15 -> 0
      do_reset();
      tick(2);
      for (int i = 0; i < 17; i++) begin
         mode = (i % 3 == 0) ? 0 : 2;
         run_frame(1'($urandom_range(0, 1)), {$urandom(), $urandom()});
      end

      // reset mid-frame after four bytes: frame restarts with seq 0
      mode = 0;
      v1 = {$urandom(), $urandom()};
      {c1hi, c1} = v1;
      rdy1 = 1'b1;
      n = 0;
      while (obs.size() < 4 && n < 200) begin
         tick();
         n++;
      end
      check("pre_rst_bytes", 64'(obs.size()), 64'd4);
      pc = p1;
      rst_n = 1'b0;
      tick();
      check("mid_rst_valid", 64'(tx_valid), 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_pulse", 64'(p1), 64'(pc));
      rst_n = 1'b1;
      obs.delete();
      m_seq = 0;
      wait_pulse(1, pc + 1, 1'b0);
      rdy1 = 1'b0;
      tick(PS + 3);
      model_frame(1'b0, v1);
      cmp_frames("restart_frame");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
